// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state type and default operand width
package serial_subtractor_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit subtract with borrow-in and borrow-out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned A - B, LSB first, one bit per cycle
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bin_q, bin_d, borrow_q, borrow_d;
  logic d, bout;
  full_subtractor u_fs (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (bin_q),
    .d   (d),
    .bout(bout)
  );
  // Next state: shift one bit per RUN cycle; the last bit lands straight in Diff/Borrow
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = {d, res_q[WIDTH-1:1]};
      bin_d = bout;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d  = DONE;
        diff_d   = {d, res_q[WIDTH-1:1]};
        borrow_d = bout;
      end
    end else if (start) begin
      state_d = RUN;
      a_d     = A;
      b_d     = B;
      res_d   = '0;
      bin_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end
  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
    end
  end
  assign busy   = state_q == RUN;
  assign done   = state_q == DONE;
  assign Diff   = diff_q;
  assign Borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized + directed scoreboard bench for serial_subtractor
module tb_serial_subtractor;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] d;
    logic         b;
    int           due;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0, busy, done, Borrow;
  logic [W-1:0] A = '0, B = '0, Diff;
  exp_t q[$];
  int cyc = 0, free_at = 0, tests = 0, fails = 0;
  logic [W-1:0] last_d = '0;
  logic last_b = 0;
  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Diff(Diff), .Borrow(Borrow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  // Reference model: an operation is accepted whenever start is seen and the previous one has finished
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      free_at = 0;
    end else if (start && cyc >= free_at) begin
      q.push_back('{d: W'(A - B), b: (A < B), due: cyc + W + 1});
      free_at = cyc + W + 1;
    end
    cyc = cyc + 1;
  end
  // Monitor: results on done, stable outputs while busy
  always @(negedge clk) begin
    if (!rst_n) begin
      last_d = '0;
      last_b = 0;
    end else if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", 32'(Diff), 32'(e.d));
        chk("borrow", 32'(Borrow), 32'(e.b));
        chk("latency", 32'(cyc), 32'(e.due));
        last_d = Diff;
        last_b = Borrow;
      end
    end else if (busy) begin
      chk("diff_hold", 32'(Diff), 32'(last_d));
      chk("borrow_hold", 32'(Borrow), 32'(last_b));
    end
  end
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1; A = a; B = b;
    tick();
    start = 0;
    repeat (W + 2) tick();
  endtask
  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_diff", 32'(Diff), 32'(0));
    chk("rst_borrow", 32'(Borrow), 32'(0));
    tick();
    rst_n = 1;
    op(8'h05, 8'h03);
    op(8'h03, 8'h05);
    op(8'h00, 8'hFF);
    op(8'hFF, 8'hFF);
    start = 1; A = 8'h10; B = 8'h01;
    tick();
    start = 0;
    tick();
    start = 1; A = 8'hAA; B = 8'h55;
    tick();
    start = 0; A = 8'h3C; B = 8'hC3;
    repeat (W + 2) tick();
    start = 1; A = 8'h80; B = 8'h7F;
    repeat (3 * (W + 1)) tick();
    start = 0;
    repeat (W + 2) tick();
    start = 1; A = 8'h33; B = 8'h11;
    tick();
    start = 0;
    repeat (3) tick();
    rst_n = 0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_diff", 32'(Diff), 32'(0));
    chk("abort_borrow", 32'(Borrow), 32'(0));
    tick();
    rst_n = 1;
    op(8'h09, 8'h04);
    repeat (400) begin
      start = ($urandom_range(0, 3) == 0);
      A = W'($urandom);
      B = W'($urandom);
      tick();
    end
    start = 0;
    repeat (W + 3) tick();
    chk("pending_results", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
